// File: rtl/mips_pipe_ctrl.sv
// mips_pipe_ctrl: MIPS decode plus E/M/W control pipeline with a multi-cycle HI/LO sequencer
module mips_pipe_ctrl #(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 12,
   parameter int CNT_W   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opD,
   input  logic [5:0] functD,
   input  logic       equalD,
   input  logic       flushE,
   output logic       pcsrcD,
   output logic       branchD,
   output logic       jumpD,
   output logic       zeroextendD,
   output logic       mdstallD,
   output logic       memtoregE,
   output logic       memtoregM,
   output logic       memtoregW,
   output logic       regwriteE,
   output logic       regwriteM,
   output logic       regwriteW,
   output logic       memwriteM,
   output logic       alusrcE,
   output logic       regdstE,
   output logic       linkE,
   output logic [5:0] alucontrolE,
   output logic       mdstartE,
   output logic       mdbusy
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic regwriteD, regdstD, alusrcD, memtoregD, memwriteD, linkD, mdD, divD, mfD;
   logic memwriteE, mddivE;
   logic [5:0] alucontrolD;
   assign mdD = opD == 6'h00 && functD[5:2] == 4'b0110;
   assign divD = mdD & functD[1];
   assign mfD = opD == 6'h00 && (functD == 6'h10 || functD == 6'h12);
   always_comb begin
      regwriteD = 1'b0;
      regdstD = 1'b0;
      alusrcD = 1'b0;
      memtoregD = 1'b0;
      memwriteD = 1'b0;
      branchD = 1'b0;
      jumpD = 1'b0;
      zeroextendD = 1'b0;
      linkD = 1'b0;
      alucontrolD = 6'h00;
      case (opD)
         6'h00: begin regwriteD = !mdD; regdstD = 1'b1; alucontrolD = functD; end
         6'h23: begin regwriteD = 1'b1; alusrcD = 1'b1; memtoregD = 1'b1; alucontrolD = 6'h20; end
         6'h2B: begin memwriteD = 1'b1; alusrcD = 1'b1; alucontrolD = 6'h20; end
         6'h08: begin regwriteD = 1'b1; alusrcD = 1'b1; alucontrolD = 6'h20; end
         6'h0C: begin regwriteD = 1'b1; alusrcD = 1'b1; zeroextendD = 1'b1; alucontrolD = 6'h24; end
         6'h0D: begin regwriteD = 1'b1; alusrcD = 1'b1; zeroextendD = 1'b1; alucontrolD = 6'h25; end
         6'h0A: begin regwriteD = 1'b1; alusrcD = 1'b1; alucontrolD = 6'h2A; end
         6'h04, 6'h05: begin branchD = 1'b1; alucontrolD = 6'h22; end
         6'h02: jumpD = 1'b1;
         6'h03: begin jumpD = 1'b1; regwriteD = 1'b1; linkD = 1'b1; end
         default: ;
      endcase
   end
   assign pcsrcD = branchD & (equalD ^ (opD == 6'h05));
   // start cycle stalls too, since mdbusy only rises the cycle after mdstartE
   assign mdstallD = (mdD | mfD) & (mdbusy | mdstartE);
   always_ff @(posedge clk) begin
      if (reset || flushE)
         {memtoregE, memwriteE, alusrcE, regdstE, regwriteE, linkE, mdstartE, mddivE, alucontrolE} <= '0;
      else
         {memtoregE, memwriteE, alusrcE, regdstE, regwriteE, linkE, mdstartE, mddivE, alucontrolE} <=
            {memtoregD, memwriteD, alusrcD, regdstD, (mdD ? 1'b0 : regwriteD), linkD, mdD, divD, alucontrolD};
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         {memtoregM, memwriteM, regwriteM} <= '0;
         {memtoregW, regwriteW} <= '0;
      end else begin
         {memtoregM, memwriteM, regwriteM} <= {memtoregE, memwriteE, regwriteE};
         {memtoregW, regwriteW} <= {memtoregM, regwriteM};
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
      end
   end
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      if (mdstartE) begin
         state_n = BUSY;
         cnt_n = mddivE ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
      end else if (state == BUSY) begin
         state_n = cnt == '0 ? IDLE : BUSY;
         cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
      end
   end
   assign mdbusy = state == BUSY;
endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// tb_mips_pipe_ctrl: directed scenarios plus random traffic against a table-driven reference model
module tb_mips_pipe_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [5:0] opD = 6'h3F, functD = 6'h00;
   logic equalD = 1'b0, flushE = 1'b0;
   logic pcsrcD, branchD, jumpD, zeroextendD, mdstallD;
   logic memtoregE, memtoregM, memtoregW, regwriteE, regwriteM, regwriteW, memwriteM;
   logic alusrcE, regdstE, linkE, mdstartE, mdbusy;
   logic [5:0] alucontrolE;
   logic pcsrc1, branch1, jump1, zext1, mdstall1, mre1, mrm1, mrw1, rwe1, rwm1, rww1, mwm1;
   logic ase1, rde1, lke1, mdstart1, mdbusy1;
   logic [5:0] alu1;
   int vecs = 0, errs = 0;

   always #5 clk = ~clk;

   mips_pipe_ctrl dut (
      .clk(clk), .reset(reset), .opD(opD), .functD(functD), .equalD(equalD), .flushE(flushE),
      .pcsrcD(pcsrcD), .branchD(branchD), .jumpD(jumpD), .zeroextendD(zeroextendD), .mdstallD(mdstallD),
      .memtoregE(memtoregE), .memtoregM(memtoregM), .memtoregW(memtoregW),
      .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW), .memwriteM(memwriteM),
      .alusrcE(alusrcE), .regdstE(regdstE), .linkE(linkE), .alucontrolE(alucontrolE),
      .mdstartE(mdstartE), .mdbusy(mdbusy)
   );

   mips_pipe_ctrl #(.MUL_LAT(1), .DIV_LAT(3), .CNT_W(2)) u1 (
      .clk(clk), .reset(reset), .opD(opD), .functD(functD), .equalD(equalD), .flushE(flushE),
      .pcsrcD(pcsrc1), .branchD(branch1), .jumpD(jump1), .zeroextendD(zext1), .mdstallD(mdstall1),
      .memtoregE(mre1), .memtoregM(mrm1), .memtoregW(mrw1),
      .regwriteE(rwe1), .regwriteM(rwm1), .regwriteW(rww1), .memwriteM(mwm1),
      .alusrcE(ase1), .regdstE(rde1), .linkE(lke1), .alucontrolE(alu1),
      .mdstartE(mdstart1), .mdbusy(mdbusy1)
   );

   typedef struct packed {
      logic rw, rd, as, mr, mw, br, jp, zx, lk, md, dv;
      logic [5:0] alu;
   } ctl_t;

   function automatic ctl_t dec(input logic [5:0] op, input logic [5:0] f);
      ctl_t c = '0;
      case (op)
         6'h00: begin
            c.md = f inside {6'h18, 6'h19, 6'h1A, 6'h1B};
            c.dv = f inside {6'h1A, 6'h1B};
            c.rw = !c.md; c.rd = 1'b1; c.alu = f;
         end
         6'h23: begin c.rw = 1'b1; c.as = 1'b1; c.mr = 1'b1; c.alu = 6'h20; end
         6'h2B: begin c.mw = 1'b1; c.as = 1'b1; c.alu = 6'h20; end
         6'h08: begin c.rw = 1'b1; c.as = 1'b1; c.alu = 6'h20; end
         6'h0C: begin c.rw = 1'b1; c.as = 1'b1; c.zx = 1'b1; c.alu = 6'h24; end
         6'h0D: begin c.rw = 1'b1; c.as = 1'b1; c.zx = 1'b1; c.alu = 6'h25; end
         6'h0A: begin c.rw = 1'b1; c.as = 1'b1; c.alu = 6'h2A; end
         6'h04, 6'h05: begin c.br = 1'b1; c.alu = 6'h22; end
         6'h02: c.jp = 1'b1;
         6'h03: begin c.jp = 1'b1; c.rw = 1'b1; c.lk = 1'b1; end
         default: ;
      endcase
      return c;
   endfunction

   // model: E bundle, M/W bits, and remaining busy cycles for each latency setting
   ctl_t e, d;
   logic [2:0] m;
   logic [1:0] w;
   int left0 = 0, left1 = 0;
   logic want_stall;
   logic [22:0] act, exp_v;
   logic [1:0] act1, exp1;

   always @(posedge clk) begin
      if (reset) begin
         e <= '0; m <= '0; w <= '0; left0 <= 0; left1 <= 0;
      end else begin
         e <= flushE ? '0 : dec(opD, functD);
         m <= {e.mr, e.mw, e.rw};
         w <= {m[2], m[0]};
         left0 <= e.md ? (e.dv ? 12 : 4) : (left0 > 0 ? left0 - 1 : 0);
         left1 <= e.md ? (e.dv ? 3 : 1) : (left1 > 0 ? left1 - 1 : 0);
      end
   end

   always_comb begin
      d = dec(opD, functD);
      want_stall = d.md | (opD == 6'h00 && (functD == 6'h10 || functD == 6'h12));
      exp_v = {d.br & (equalD ^ (opD == 6'h05)), d.br, d.jp, d.zx, want_stall & (left0 > 0 || e.md),
               e.mr, m[2], w[1], e.rw, m[0], w[0], m[1], e.as, e.rd, e.lk, e.alu, e.md, left0 > 0};
      exp1 = {want_stall & (left1 > 0 || e.md), left1 > 0};
      act = {pcsrcD, branchD, jumpD, zeroextendD, mdstallD, memtoregE, memtoregM, memtoregW,
             regwriteE, regwriteM, regwriteW, memwriteM, alusrcE, regdstE, linkE, alucontrolE, mdstartE, mdbusy};
      act1 = {mdstall1, mdbusy1};
   end

   task automatic tick(input logic [5:0] op, input logic [5:0] f, input logic eq, input logic fl, input logic rs);
      @(negedge clk);
      opD = op; functD = f; equalD = eq; flushE = fl; reset = rs;
      #1;
   endtask

   task automatic test_reset;
      tick(6'h3F, 6'h00, 0, 0, 1);
      tick(6'h3F, 6'h00, 0, 0, 1);
      vecs++;
      if (act !== 23'd0) begin errs++; $display("FAIL reset_all got %h want 0", act); end
      tick(6'h23, 6'h00, 0, 0, 1);
      tick(6'h3F, 6'h00, 0, 0, 1);
      vecs++;
      if ({memtoregE, alusrcE, regwriteE} !== 3'b000) begin
         errs++; $display("FAIL reset_holdE got %b want 000", {memtoregE, alusrcE, regwriteE});
      end
   endtask

   task automatic test_lw;
      tick(6'h23, 6'h00, 0, 0, 0);
      tick(6'h3F, 6'h00, 0, 0, 0);
      vecs++;
      if ({memtoregE, alusrcE, alucontrolE} !== {2'b11, 6'h20}) begin
         errs++; $display("FAIL lw_E got %b want %b", {memtoregE, alusrcE, alucontrolE}, {2'b11, 6'h20});
      end
      tick(6'h3F, 6'h00, 0, 0, 0);
      tick(6'h3F, 6'h00, 0, 0, 0);
      vecs++;
      if ({memtoregW, regwriteW} !== 2'b11) begin
         errs++; $display("FAIL lw_W got %b want 11", {memtoregW, regwriteW});
      end
   endtask

   task automatic test_branch;
      for (int i = 0; i < 4; i++) begin
         logic [1:0] s;
         s = 2'(i);
         tick(s[1] ? 6'h05 : 6'h04, 6'h00, s[0], 0, 0);
         vecs++;
         if ({branchD, pcsrcD} !== {1'b1, s[1] ^ s[0]}) begin
            errs++; $display("FAIL branch_%0d got %b want %b", i, {branchD, pcsrcD}, {1'b1, s[1] ^ s[0]});
         end
      end
   endtask

   task automatic test_jal;
      tick(6'h03, 6'h00, 0, 0, 0);
      vecs++;
      if (jumpD !== 1'b1) begin errs++; $display("FAIL jal_D got %b want 1", jumpD); end
      tick(6'h3F, 6'h00, 0, 0, 0);
      vecs++;
      if ({linkE, regwriteE} !== 2'b11) begin errs++; $display("FAIL jal_E got %b want 11", {linkE, regwriteE}); end
   endtask

   task automatic test_mult_stall;
      int ns = 0, nb = 0;
      tick(6'h3F, 6'h00, 0, 0, 1);
      tick(6'h00, 6'h18, 0, 0, 0);
      vecs++;
      if (mdstallD !== 1'b0) begin errs++; $display("FAIL mult_idle got %b want 0", mdstallD); end
      for (int k = 0; k < 7; k++) begin
         tick(6'h00, 6'h10, 0, 0, 0);
         ns += int'(mdstallD);
         nb += int'(mdbusy);
         vecs++;
         if ({mdstallD, mdbusy, mdbusy1} !== {k < 5, k >= 1 && k < 5, k == 1}) begin
            errs++; $display("FAIL mfhi_c%0d got %b want %b", k, {mdstallD, mdbusy, mdbusy1}, {k < 5, k >= 1 && k < 5, k == 1});
         end
      end
      vecs++;
      if (ns != 5 || nb != 4) begin errs++; $display("FAIL mult_counts got %0d/%0d want 5/4", ns, nb); end
   endtask

   task automatic test_div_flush;
      tick(6'h3F, 6'h00, 0, 0, 1);
      tick(6'h00, 6'h1A, 0, 1, 0);
      tick(6'h3F, 6'h00, 0, 0, 0);
      vecs++;
      if ({mdstartE, mdbusy, memtoregE, regwriteE, alusrcE, regdstE, linkE, alucontrolE} !== 13'd0) begin
         errs++; $display("FAIL div_flushE got %b want 0", {mdstartE, mdbusy, memtoregE, regwriteE, alusrcE, regdstE, linkE, alucontrolE});
      end
      tick(6'h3F, 6'h00, 0, 0, 0);
      vecs++;
      if (mdbusy !== 1'b0) begin errs++; $display("FAIL div_flush_busy got %b want 0", mdbusy); end
   endtask

   task automatic test_div_reset;
      int nb = 0;
      tick(6'h3F, 6'h00, 0, 0, 1);
      tick(6'h00, 6'h1A, 0, 0, 0);
      tick(6'h3F, 6'h00, 0, 0, 0);
      vecs++;
      if (mdstartE !== 1'b1) begin errs++; $display("FAIL div_start got %b want 1", mdstartE); end
      for (int k = 0; k < 5; k++) begin
         tick(6'h3F, 6'h00, 0, 0, 0);
         vecs++;
         if (mdbusy !== 1'b1) begin errs++; $display("FAIL div_busy_%0d got %b want 1", k, mdbusy); end
      end
      tick(6'h3F, 6'h00, 0, 0, 1);
      tick(6'h3F, 6'h00, 0, 0, 0);
      vecs++;
      if (act !== 23'd0) begin errs++; $display("FAIL div_abort got %h want 0", act); end
      tick(6'h00, 6'h19, 0, 0, 0);
      for (int k = 0; k < 8; k++) begin
         tick(6'h3F, 6'h00, 0, 0, 0);
         nb += int'(mdbusy);
      end
      vecs++;
      if (nb != 4) begin errs++; $display("FAIL mult_after_abort got %0d want 4", nb); end
   endtask

   task automatic test_random;
      logic [5:0] ops [12] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};
      logic [5:0] fns [12] = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
      tick(6'h3F, 6'h00, 0, 0, 1);
      for (int n = 0; n < 600; n++) begin
         int a, b;
         logic [5:0] op, f;
         a = int'($urandom_range(0, 11));
         b = int'($urandom_range(0, 11));
         op = (a == 11) ? 6'($urandom) : ops[a];
         f = (b == 11) ? 6'($urandom) : fns[b];
         tick(op, f, 1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0);
         vecs++;
         if (act !== exp_v || act1 !== exp1) begin
            errs++; $display("FAIL rand_%0d op=%h f=%h got %h/%b want %h/%b", n, op, f, act, act1, exp_v, exp1);
         end
      end
   endtask

   initial begin
      test_reset;
      test_lw;
      test_branch;
      test_jal;
      test_mult_stall;
      test_div_flush;
      test_div_reset;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/mips_pipe_ctrl.md
# mips_pipe_ctrl

Parametrised pipelined control unit for the five-stage MIPS core. Decodes the instruction in Decode and carries its control bundle through the Execute, Memory and Writeback pipeline registers with flush support. Adds `bne`/`jal` decode and a multi-cycle multiply/divide sequencer that raises a decode-stage stall for the hazard unit. Sits between the instruction register and the datapath, beside the hazard unit.

## Interface
- `MUL_LAT`, default 4: cycles the HI/LO unit needs for `mult`/`multu`; legal range is ≥1.
- `DIV_LAT`, default 12: cycles for `div`/`divu`; legal range is ≥1.
- `CNT_W`, default 4: busy-counter width; must hold max(MUL_LAT, DIV_LAT).
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `opD`  in  6  opcode of the Decode instruction.
- `functD`  in  6  funct field of the Decode instruction.
- `equalD`  in  1  register-compare result from the datapath.
- `flushE`  in  1  loads a bubble into the E register.
- `pcsrcD`, `branchD`, `jumpD`, `zeroextendD`  out  1 each  Decode-stage controls.
- `mdstallD`  out  1  Decode must stall for the HI/LO unit.
- `memtoregE/M/W`, `regwriteE/M/W`, `memwriteM`, `alusrcE`, `regdstE`, `linkE`  out  1 each  staged controls.
- `alucontrolE`  out  6  ALU operation.
- `mdstartE`  out  1  starts the HI/LO unit this cycle.
- `mdbusy`  out  1  HI/LO result not yet valid.

## Operation
- Decode (opcode / funct, hex):
  - R-type (00): regwrite, regdst, alucontrol = funct. For mult/multu/div/divu (18/19/1A/1B), regwrite = 0 and md-start = 1.
  - lw (23): regwrite, alusrc, memtoreg, alucontrol 20.
  - sw (2B): memwrite, alusrc, alucontrol 20.
  - addi (08): regwrite, alusrc, alucontrol 20.
  - andi (0C) and ori (0D): regwrite, alusrc, zeroextend; alucontrol 24 and 25 respectively.
  - slti (0A): regwrite, alusrc, alucontrol 2A.
  - beq (04) and bne (05): branch, alucontrol 22.
  - j (02): jump.
  - jal (03): jump, regwrite, link.
  - Any other opcode decodes to all-zero controls (NOP).
- `pcsrcD = branchD & (equalD XOR (opD==05))`. This output is combinational.
- E register (≥13 bits): memtoreg, memwrite, alusrc, regdst, regwrite, link, md-start, md-is-div, alucontrol.
  - Loads the Decode bundle each cycle.
  - Loads zeros when `flushE` or `reset` is asserted; `reset` has priority.
- M register: memtoreg, memwrite, regwrite. W register: memtoreg, regwrite. Both load unconditionally; `reset` clears them.
- Sequencer states: IDLE and BUSY.
  - IDLE → BUSY when `mdstartE`=1. Counter loads DIV_LAT−1 if md-is-div, else MUL_LAT−1.
  - BUSY: counter decrements each cycle. BUSY → IDLE on the cycle after the counter reaches 0.
  - `mdbusy` is 1 in BUSY, 0 in IDLE.
  - If a second `mdstartE` arrives while BUSY, the counter reloads for the new op. The state stays BUSY.
- `mdstallD` = (Decode instr is mfhi 10, mflo 12, or any mult/div) AND (`mdbusy` OR `mdstartE`).
- `mdstallD` is combinational. The hazard unit ORs it into stallF/stallD and asserts `flushE` for it.

## Timing
- Reset: all staged outputs, `mdstartE` and `mdbusy` are 0 the cycle after `reset` is sampled high. Counter = 0, state = IDLE.
- Decode outputs (`pcsrcD`, `branchD`, `jumpD`, `zeroextendD`, `mdstallD`) are combinational from the inputs and current state. They have no reset dependence except through `mdbusy`.
- Latency: the D bundle appears on E outputs 1 cycle later, M after 2 cycles, W after 3 cycles.
- `mdstartE` is high for exactly one cycle per mult/div that reaches E unflushed.
- `mdbusy` is high for exactly LAT consecutive cycles, starting the cycle after `mdstartE`.
- A mult/div flushed in E never starts the sequencer.
- `flushE` has no effect on M/W or on an operation already BUSY.
- Reset during BUSY aborts the operation immediately: `mdbusy` = 0 the next cycle.
- MUL_LAT = 1: `mdbusy` is high for one cycle.

## Test plan
- Reset then lw (op 23) in D → cycle+1: memtoregE=1, alusrcE=1, alucontrolE=20. Cycle+3: memtoregW=1, regwriteW=1.
- bne (op 05) with equalD=0 → pcsrcD=1. Same with equalD=1 → pcsrcD=0. beq gives the inverse results.
- jal (op 03) → jumpD=1 combinationally. Next cycle: linkE=1, regwriteE=1.
- mult (00/18) into E, then mfhi held in D: with MUL_LAT=4, `mdstallD` is high for 5 cycles (the start cycle plus 4 busy cycles), then low. `mdbusy` is high for 4 cycles.
- div with `flushE` asserted the cycle it would enter E → `mdstartE`=0, `mdbusy` stays 0, all E outputs 0.
- div started (DIV_LAT=12), `reset` asserted after 5 busy cycles → next cycle `mdbusy`=0 and all pipeline outputs 0. A subsequent mult runs exactly 4 busy cycles.
